// File: rtl/mfp_adc_max10_avg.sv
// Oversampling/averaging stage on the MAX10 ADC response stream: one averaged beat per channel per round.
// Define ADC_AVG_ROUND_EN to round complete-cell averages half up instead of truncating.
module mfp_adc_max10_avg #(
  parameter  int LOG2_SAMPLES = 2,
  parameter  int DATA_WIDTH   = 12,
  localparam int RW           = (LOG2_SAMPLES > 0) ? LOG2_SAMPLES : 1
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  input  logic                  in_Valid,
  input  logic [4:0]            in_Channel,
  input  logic [DATA_WIDTH-1:0] in_Data,
  input  logic                  in_SOP,
  input  logic                  in_EOP,
  input  logic                  avg_clear,
  output logic                  out_Valid,
  output logic [4:0]            out_Channel,
  output logic [DATA_WIDTH-1:0] out_Data,
  output logic                  out_SOP,
  output logic                  out_EOP,
  output logic [RW-1:0]         round_idx
);

  localparam int NCELL = 7;
  localparam int AW    = DATA_WIDTH + LOG2_SAMPLES + 1;
  localparam int CW    = LOG2_SAMPLES + 1;
  localparam logic [RW-1:0] RND_LAST = RW'((1 << LOG2_SAMPLES) - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'((1 << LOG2_SAMPLES) - 1);

  logic [AW-1:0]         acc_q [NCELL];
  logic [AW-1:0]         acc_d [NCELL];
  logic [CW-1:0]         cnt_q [NCELL];
  logic [CW-1:0]         cnt_d [NCELL];
  logic [RW-1:0]         rnd_q, rnd_d;
  logic                  out_valid_q, out_valid_d;
  logic [4:0]            out_ch_q, out_ch_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_sop_q, out_sop_d;
  logic                  out_eop_q, out_eop_d;

  logic                  cell_hit;
  logic [2:0]            cell_idx;
  logic                  final_pkt;
  logic [AW:0]           sum, sum_r;
  logic [DATA_WIDTH-1:0] avg;

  // Channels 1..6 map to cells 0..5, channel 17 (temperature sensor) to cell 6.
  always_comb begin
    cell_hit = 1'b1;
    cell_idx = 3'd0;
    case (in_Channel)
      5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6: cell_idx = in_Channel[2:0] - 3'd1;
      5'd17:                              cell_idx = 3'd6;
      default:                            cell_hit = 1'b0;
    endcase
  end

  assign final_pkt = (rnd_q == RND_LAST);
  assign sum       = {1'b0, acc_q[cell_idx]} + (AW+1)'(in_Data);

`ifdef ADC_AVG_ROUND_EN
  localparam logic [AW:0] HALF = (AW+1)'((LOG2_SAMPLES > 0) ? (1 << (LOG2_SAMPLES - 1)) : 0);
  assign sum_r = sum + HALF;
`else
  assign sum_r = sum;
`endif

  assign avg = DATA_WIDTH'(sum_r >> LOG2_SAMPLES);

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    rnd_d       = rnd_q;
    out_valid_d = 1'b0;
    out_ch_d    = 5'd0;
    out_data_d  = '0;
    out_sop_d   = 1'b0;
    out_eop_d   = 1'b0;
    if (avg_clear) begin
      for (int i = 0; i < NCELL; i++) begin
        acc_d[i] = '0;
        cnt_d[i] = '0;
      end
      rnd_d = '0;
    end else if (in_Valid) begin
      if (in_EOP) rnd_d = final_pkt ? '0 : rnd_q + RW'(1);
      if (final_pkt) begin
        out_valid_d = 1'b1;
        out_ch_d    = in_Channel;
        out_sop_d   = in_SOP;
        out_eop_d   = in_EOP;
        out_data_d  = (cell_hit && cnt_q[cell_idx] == CNT_FULL) ? avg : in_Data;
        if (cell_hit) begin
          acc_d[cell_idx] = '0;
          cnt_d[cell_idx] = '0;
        end
        // Closing EOP empties every cell so the next round starts clean.
        if (in_EOP) begin
          for (int i = 0; i < NCELL; i++) begin
            acc_d[i] = '0;
            cnt_d[i] = '0;
          end
        end
      end else if (cell_hit) begin
        acc_d[cell_idx] = acc_q[cell_idx] + AW'(in_Data);
        if (cnt_q[cell_idx] != '1) cnt_d[cell_idx] = cnt_q[cell_idx] + CW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      for (int i = 0; i < NCELL; i++) begin
        acc_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      rnd_q       <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= 5'd0;
      out_data_q  <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      rnd_q       <= rnd_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
    end
  end

  assign out_Valid   = out_valid_q;
  assign out_Channel = out_ch_q;
  assign out_Data    = out_data_q;
  assign out_SOP     = out_sop_q;
  assign out_EOP     = out_eop_q;
  assign round_idx   = rnd_q;

endmodule
